axis_vfifo_traffic_gen: RTL
===========================

Name: axis_vfifo_traffic_gen

Overview:
Synthesizable AXI-stream traffic generator and checker for the DDR-backed virtual FIFO, with a parametrised number of channels.
- Writes WRITE_DEPTH words per run, interleaving channels burst by burst via tdest.
- Reads them back and checks each word against a per-channel expected sequence.
- Repeats for NUM_RUNS runs.
- Sits between the control/status registers and the VFIFO stream ports; used for on-board soak tests and for simulation.

Parameters:
DATA_WIDTH, 32, stream data width in bits (>= DEST_WIDTH+8)
NUM_CHANNELS, 2, number of VFIFO channels exercised (1..2**DEST_WIDTH)
DEST_WIDTH, 1, tdest width
BURST_LEN, 128, beats per burst; tlast is asserted on the last beat of each burst
WRITE_DEPTH, 4096, words written per run (multiple of BURST_LEN)
READ_TIMEOUT, 4096, consecutive idle read cycles before the read phase is abandoned
WAIT_CYCLES, 0, idle cycles inserted after each write burst (0 = none)
NUM_RUNS, 2, write/read runs per start

Ports:
aclk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; starts a test from IDLE or DONE
m_axis_tvalid  out  1  write stream to VFIFO
m_axis_tready  in  1
m_axis_tdata  out  DATA_WIDTH
m_axis_tlast  out  1
m_axis_tdest  out  DEST_WIDTH
s_axis_tvalid  in  1  read stream from VFIFO
s_axis_tready  out  1
s_axis_tdata  in  DATA_WIDTH
s_axis_tdest  in  DEST_WIDTH
busy  out  1  high in WR, WR_WAIT, RD
done  out  1  high in DONE
runs_done  out  8  completed runs
err_count  out  16  data mismatches, saturating at 0xFFFF
first_err_data  out  DATA_WIDTH  received word of the first mismatch
timeout_flag  out  1  sticky; a read phase ended by timeout
state  out  3  IDLE=0, WR=1, WR_WAIT=2, RD=3, DONE=4

Behaviour:
- Reset: every output is 0; state=IDLE; sequence counters, error capture and run counter are cleared. Reset mid-operation aborts immediately.
- Word format:
  - tdata[DATA_WIDTH-1 -: DEST_WIDTH] = channel.
  - Low DATA_WIDTH-DEST_WIDTH bits = that channel's write sequence number (starts at 0, wraps modulo 2**(DATA_WIDTH-DEST_WIDTH)).
  - Sequence numbers continue across runs; they are cleared only by start and by reset.
- IDLE/DONE -> WR on start:
  - Clears runs_done, err_count, first_err_data, timeout_flag and all sequence counters.
  - start in any other state is ignored.
- WR:
  - m_axis_tvalid=1 registered. The beat is accepted on tvalid&&tready.
  - tdata, tlast and tdest hold stable while tvalid=1 and tready=0.
  - Burst b (0-based within the run) targets channel b mod NUM_CHANNELS.
  - tlast=1 on beat BURST_LEN-1 of each burst.
  - After the accepted tlast beat:
    - WAIT_CYCLES>0 -> WR_WAIT with tvalid=0.
    - WAIT_CYCLES=0 -> next burst back-to-back with no bubble.
  - After WRITE_DEPTH accepted beats -> RD; tvalid drops in the same cycle as the RD entry.
- WR_WAIT: counts exactly WAIT_CYCLES cycles with tvalid=0, then returns to WR.
- RD:
  - s_axis_tready=1. Each beat is accepted on s_axis_tvalid&&tready.
  - Each accepted beat is compared with the word {tdest, exp_seq[tdest]}; exp_seq[tdest] then increments whether or not it matched.
  - A mismatch increments err_count (saturating). If err_count was 0, first_err_data is also captured.
  - tdest >= NUM_CHANNELS counts as a mismatch; no exp_seq is updated.
  - Idle counter: resets on each accepted beat, increments otherwise.
  - Exit RD when WRITE_DEPTH beats are received, or when the idle counter reaches READ_TIMEOUT (then timeout_flag is set).
  - On exit: tready=0 in the next cycle; runs_done increments.
  - If runs_done+1 == NUM_RUNS -> DONE, else -> WR.
- On timeout, the unreceived words of each channel are not skipped. Later runs will then report mismatches; this is intended.
- Latency: first write beat presented 1 cycle after start. Status outputs are registered and update 1 cycle after the event.

Optional Feature:
AXIS_TG_PRBS_EN
- Defined: the sequence field is a per-channel 31-bit Fibonacci LFSR, polynomial x^31+x^28+1, seed = channel+1. It is zero-extended or truncated to the field width and advanced once per accepted beat. The checker keeps an identical LFSR per channel.
- Undefined: a plain binary counter, as described in Behaviour.

Test Plan:
- Reset mid-WR (beat 37) -> the next cycle shows all outputs 0 and state=0; the next start writes ch0 seq 0 first.
- Defaults with a loopback FIFO that is always ready:
  - runs 1-2 write 4096 beats each; tdest alternates 0/1 every 128 beats.
  - tlast is seen on beats 127, 255, ...
  - result: done=1, runs_done=2, err_count=0, timeout_flag=0.
- Random m_axis_tready stalls, 30% low -> tdata, tlast and tdest are unchanged during stalls and err_count=0.
- WAIT_CYCLES=3 -> exactly 3 cycles with tvalid=0 after each tlast beat, and no gap inside a burst.
- Loopback corrupts one word (ch1 seq 5 -> value+1) -> err_count=1 and first_err_data equals the corrupted word. The following ch1 words still match.
- Read side drops the last 10 words, READ_TIMEOUT=64:
  - run 1 ends by timeout and timeout_flag=1;
  - run 2 reports err_count > 0;
  - runs_done=2 and done=1.

Source files
------------

// File: rtl/axis_vfifo_traffic_gen.sv
// axis_vfifo_traffic_gen: AXI-stream write/read-back soak generator and checker for the DDR virtual FIFO.
// Define AXIS_TG_PRBS_EN to replace the per-channel sequence counters with PRBS-31 LFSRs.
module axis_vfifo_traffic_gen #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_CHANNELS = 2,
   parameter int DEST_WIDTH   = 1,
   parameter int BURST_LEN    = 128,
   parameter int WRITE_DEPTH  = 4096,
   parameter int READ_TIMEOUT = 4096,
   parameter int WAIT_CYCLES  = 0,
   parameter int NUM_RUNS     = 2
) (
   input  logic                  aclk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            runs_done,
   output logic [15:0]           err_count,
   output logic [DATA_WIDTH-1:0] first_err_data,
   output logic                  timeout_flag,
   output logic [2:0]            state
);
   localparam int SEQ_W = DATA_WIDTH - DEST_WIDTH;
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int CW = $clog2(WRITE_DEPTH + 1);
   localparam int TW = $clog2(READ_TIMEOUT + 1);
   localparam int WW = $clog2(WAIT_CYCLES + 2);
`ifdef AXIS_TG_PRBS_EN
   localparam int SW = 31;
   localparam bit SEEDED = 1'b1;
   function automatic logic [SW-1:0] seq_next(input logic [SW-1:0] s);
      return {s[29:0], s[30] ^ s[27]};
   endfunction
`else
   localparam int SW = SEQ_W;
   localparam bit SEEDED = 1'b0;
   function automatic logic [SW-1:0] seq_next(input logic [SW-1:0] s);
      return s + 1'b1;
   endfunction
`endif

   typedef enum logic [2:0] {IDLE = 3'd0, WR = 3'd1, WR_WAIT = 3'd2, RD = 3'd3, DONE = 3'd4} state_t;
   state_t state_q, state_d;

   logic [SW-1:0]         wr_seq_q  [NUM_CHANNELS];
   logic [SW-1:0]         exp_seq_q [NUM_CHANNELS];
   logic [BW-1:0]         beat_q;
   logic [CW-1:0]         wr_cnt_q, rd_cnt_q;
   logic [TW-1:0]         idle_q;
   logic [WW-1:0]         wait_q;
   logic [DEST_WIDTH-1:0] ch_q;
   logic [7:0]            runs_q;
   logic [15:0]           err_q;
   logic [DATA_WIDTH-1:0] first_err_q;
   logic                  to_q;

   logic go, wr_fire, last_beat, wr_end, wait_end, rd_fire, dest_ok, mismatch, rd_to, rd_end;
   logic [DATA_WIDTH-1:0] exp_word;

   assign go        = start && (state_q == IDLE || state_q == DONE);
   assign wr_fire   = state_q == WR && m_axis_tready;
   assign last_beat = beat_q == BW'(BURST_LEN - 1);
   assign wr_end    = wr_fire && wr_cnt_q == CW'(WRITE_DEPTH - 1);
   assign wait_end  = wait_q == WW'(WAIT_CYCLES - 1);
   assign rd_fire   = state_q == RD && s_axis_tvalid;
   assign dest_ok   = 32'(s_axis_tdest) < NUM_CHANNELS;
   assign exp_word  = {s_axis_tdest, SEQ_W'(exp_seq_q[s_axis_tdest])};
   assign mismatch  = rd_fire && (!dest_ok || s_axis_tdata != exp_word);
   assign rd_to     = state_q == RD && !s_axis_tvalid && idle_q == TW'(READ_TIMEOUT - 1);
   assign rd_end    = (rd_fire && rd_cnt_q == CW'(WRITE_DEPTH - 1)) || rd_to;

   always_comb begin
      state_d = state_q;
      if (go)
         state_d = WR;
      else if (wr_end)
         state_d = RD;
      else if (wr_fire && last_beat && WAIT_CYCLES > 0)
         state_d = WR_WAIT;
      else if (state_q == WR_WAIT && wait_end)
         state_d = WR;
      else if (rd_end)
         state_d = (32'(runs_q) + 1 == NUM_RUNS) ? DONE : WR;
   end

   always_ff @(posedge aclk)
      state_q <= reset ? IDLE : state_d;

   // Sequence state survives across runs; only start and reset clear it.
   always_ff @(posedge aclk) begin
      if (reset || go) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            wr_seq_q[i]  <= SEEDED ? SW'(i + 1) : '0;
            exp_seq_q[i] <= SEEDED ? SW'(i + 1) : '0;
         end
         beat_q      <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         idle_q      <= '0;
         wait_q      <= '0;
         ch_q        <= '0;
         runs_q      <= '0;
         err_q       <= '0;
         first_err_q <= '0;
         to_q        <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_seq_q[ch_q] <= seq_next(wr_seq_q[ch_q]);
            beat_q         <= last_beat ? '0 : beat_q + 1'b1;
            wr_cnt_q       <= wr_cnt_q + 1'b1;
            if (last_beat)
               ch_q <= (32'(ch_q) == NUM_CHANNELS - 1) ? '0 : ch_q + 1'b1;
         end
         wait_q <= state_q == WR_WAIT ? wait_q + 1'b1 : '0;
         if (rd_fire && dest_ok)
            exp_seq_q[s_axis_tdest] <= seq_next(exp_seq_q[s_axis_tdest]);
         if (state_q == RD)
            idle_q <= rd_fire ? '0 : idle_q + 1'b1;
         if (rd_fire)
            rd_cnt_q <= rd_cnt_q + 1'b1;
         if (mismatch) begin
            err_q <= (&err_q) ? err_q : err_q + 1'b1;
            if (err_q == '0)
               first_err_q <= s_axis_tdata;
         end
         if (rd_to)
            to_q <= 1'b1;
         if (rd_end) begin
            runs_q   <= runs_q + 1'b1;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            idle_q   <= '0;
            beat_q   <= '0;
            ch_q     <= '0;
         end
      end
   end

   assign m_axis_tvalid  = state_q == WR;
   assign m_axis_tlast   = m_axis_tvalid && last_beat;
   assign m_axis_tdest   = m_axis_tvalid ? ch_q : '0;
   assign m_axis_tdata   = m_axis_tvalid ? {ch_q, SEQ_W'(wr_seq_q[ch_q])} : '0;
   assign s_axis_tready  = state_q == RD;
   assign busy           = state_q == WR || state_q == WR_WAIT || state_q == RD;
   assign done           = state_q == DONE;
   assign runs_done      = runs_q;
   assign err_count      = err_q;
   assign first_err_data = first_err_q;
   assign timeout_flag   = to_q;
   assign state          = state_q;
endmodule
